// File: rtl/rf68000_ring_inject_arb_if.sv
// Ring packet format and the local-requester handshake bundle for the
// ring injection arbiter. The package sits here because the interface
// needs packet_t and must compile before the arbiter.

package nic_pkg;

  // Destination id reserved for broadcast packets.
  localparam logic [5:0] BCAST_ID = 6'd63;

  // One ring slot. A slot with sid and did both zero is empty.
  typedef struct packed {
    logic [5:0]  did;
    logic [5:0]  sid;
    logic [5:0]  age;
    logic [31:0] data;
  } packet_t;

endpackage

// Requester side of the arbiter: request/packet in, grant/busy out.
interface rf68000_ring_inject_arb_if #(
  parameter int NREQ = 4
) ();

  logic [NREQ-1:0]                  req_i;
  nic_pkg::packet_t [NREQ-1:0]      pkt_i;
  logic [NREQ-1:0]                  gnt_o;
  logic                             busy_o;

  // Local requesters drive requests and packets.
  modport master (
    output req_i,
    output pkt_i,
    input  gnt_o,
    input  busy_o
  );

  // The arbiter consumes requests and returns grants.
  modport slave (
    input  req_i,
    input  pkt_i,
    output gnt_o,
    output busy_o
  );

endinterface

// File: rtl/rf68000_ring_inject_arb.sv
// Ring injection arbiter for one node. Forwards the ring with one clock of
// latency, ageing every hop, removes stale packets and this node's own
// returning broadcasts, and inserts the round-robin winner's packet into
// a truly empty slot.

module rf68000_ring_inject_arb
  import nic_pkg::*;
#(
  parameter int         NREQ    = 4,
  parameter logic [5:0] AGE_MAX = 6'd48
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [5:0]                    id,
  input  packet_t                       packet_i,
  output packet_t                       packet_o,
  output logic [15:0]                   drop_cnt_o,
  rf68000_ring_inject_arb_if.slave      arb
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    ARB_IDLE,
    ARB_ARMED
  } arb_state_e;

  arb_state_e       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] win_idx;
  packet_t          win_pkt;
  logic [NREQ-1:0]  gnt_q;
  logic             busy_q;

  assign arb.gnt_o  = gnt_q;
  assign arb.busy_o = busy_q;

  // Classify the incoming slot and build its aged forward copy.
  logic    slot_empty;
  logic    is_bcast;
  logic    stale;
  logic    own_bcast;
  logic    ring_drop;
  packet_t fwd_pkt;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    slot_empty = ((packet_i.sid | packet_i.did) == 6'd0);
    is_bcast   = (packet_i.did == BCAST_ID);
    stale      = !slot_empty && !is_bcast && (packet_i.age >= AGE_MAX);
    own_bcast  = is_bcast && (packet_i.sid == id);
    ring_drop  = stale || own_bcast;
    fwd_pkt    = packet_i;
    fwd_pkt.age = (packet_i.age == 6'h3F) ? 6'h3F : packet_i.age + 6'd1;
  end

  // Round-robin search starting at rr_ptr, wrapping modulo NREQ.
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W:0]   cand_sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_sum   = '0;
    cand       = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand_sum = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (cand_sum >= (IDX_W+1)'(NREQ)) begin
        cand_sum = cand_sum - (IDX_W+1)'(NREQ);
      end
      cand = cand_sum[IDX_W-1:0];
      if (!pick_found && arb.req_i[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Armed-state decisions on the latched winner.
  logic             win_req;
  logic             win_illegal;
  logic             ill_discard;
  packet_t          ins_pkt;
  logic [IDX_W-1:0] next_rr;

  always_comb begin
    win_req     = arb.req_i[win_idx];
    win_illegal = (win_pkt.did == 6'd0) || (win_pkt.did == id);
    ill_discard = (state == ARB_ARMED) && win_req && win_illegal;
    ins_pkt     = win_pkt;
    ins_pkt.sid = id;
    ins_pkt.age = (win_pkt.did == BCAST_ID) ? 6'd30 : 6'd0;
    next_rr     = (win_idx == IDX_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
  end

  // Saturating drop counter: a ring removal and an illegal discard can
  // land on the same edge, so the increment is 0..2.
  logic [1:0]  drop_inc;
  logic [16:0] drop_sum;
  logic [15:0] drop_next;

  always_comb begin
    drop_inc  = {1'b0, ring_drop} + {1'b0, ill_discard};
    drop_sum  = {1'b0, drop_cnt_o} + 17'(drop_inc);
    drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // Ring output register, drop counter and arbiter FSM in one process so
  // an insertion can override the forwarded slot on the same edge.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      // NOTE: the latched packet is cleared too, so a reset mid-operation
      // can never leave a stale payload that looks like a pending insert.
      state      <= ARB_IDLE;
      rr_ptr     <= '0;
      win_idx    <= '0;
      win_pkt    <= '0;
      gnt_q      <= '0;
      busy_q     <= 1'b0;
      packet_o   <= '0;
      drop_cnt_o <= '0;
    end else begin
      gnt_q      <= '0;
      packet_o   <= ring_drop ? '0 : fwd_pkt;
      drop_cnt_o <= drop_next;

      case (state)
        ARB_IDLE: begin
          if (pick_found) begin
            win_idx <= pick_idx;
            win_pkt <= arb.pkt_i[pick_idx];
            busy_q  <= 1'b1;
            state   <= ARB_ARMED;
          end
        end

        ARB_ARMED: begin
          if (!win_req) begin
            // Requester withdrew: abandon without grant, pointer kept.
            busy_q <= 1'b0;
            state  <= ARB_IDLE;
          end else if (win_illegal) begin
            // Unroutable packet: acknowledge and discard without a slot.
            gnt_q[win_idx] <= 1'b1;
            rr_ptr         <= next_rr;
            busy_q         <= 1'b0;
            state          <= ARB_IDLE;
          end else if (slot_empty) begin
            packet_o       <= ins_pkt;
            gnt_q[win_idx] <= 1'b1;
            rr_ptr         <= next_rr;
            busy_q         <= 1'b0;
            state          <= ARB_IDLE;
          end
        end

        default: begin
          busy_q <= 1'b0;
          state  <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule
